// File: rtl/switch_tx_mac_pkg.sv
// Shared definitions for the switch transmit MAC: FSM encoding, framing bytes and CRC-32 constants.
package switch_tx_mac_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPtrRd,
        StPtrLat,
        StPre,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// One byte step of the reflected Ethernet CRC-32; purely combinational.
module crc32_d8
    import switch_tx_mac_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = bit_rev32(CRC_POLY);

    logic [31:0] c;

    // LSB-first shift register form, so data enters without bit reversal
    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/switch_tx_mac.sv
// GMII-style transmit MAC: pops a length descriptor, frames the payload with preamble, pad and FCS.
module switch_tx_mac
    import switch_tx_mac_pkg::*;
#(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_LEN   = 60
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    input  logic        ptr_fifo_empty,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic        tx_en,
    output logic [7:0]  tx_d,
    output logic [15:0] tx_frame_cnt,
    output logic        busy
);

    localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
    localparam logic [11:0] IFG_LAST  = 12'(IFG_BYTES - 1);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
    logic        last_data;
    state_t      after_frame;
    logic        unused_desc;

    assign unused_desc = ^ptr_fifo_dout[15:12];

    crc32_d8 u_crc (
        .data    (crc_byte),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    assign crc_byte  = (state_q == StPad) ? 8'h00 : data_fifo_dout;
    assign fcs       = ~crc_q;
    assign fcs_byte  = 8'(fcs >> {cnt_q[1:0], 3'b000});
    assign last_data = (cnt_q == len_q - 12'd1);

    // A descriptor already waiting at the end of the gap is fetched without an extra IDLE cycle
    assign after_frame = ptr_fifo_empty ? StIdle : StPtrRd;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        crc_d        = crc_q;
        frame_cnt_d  = frame_cnt_q;
        tx_en_d      = 1'b0;
        tx_d_d       = 8'h00;
        ptr_fifo_rd  = 1'b0;
        data_fifo_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!ptr_fifo_empty) state_d = StPtrRd;
            end
            StPtrRd: begin
                ptr_fifo_rd = 1'b1;
                state_d     = StPtrLat;
            end
            StPtrLat: begin
                len_d   = ptr_fifo_dout[11:0];
                cnt_d   = 12'd0;
                crc_d   = CRC_INIT;
                state_d = (ptr_fifo_dout[11:0] == 12'd0) ? StIdle : StPre;
            end
            StPre: begin
                tx_en_d = 1'b1;
                tx_d_d  = PREAMBLE_BYTE;
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == 12'd6) begin
                    cnt_d   = 12'd0;
                    state_d = StSfd;
                end
            end
            StSfd: begin
                tx_en_d      = 1'b1;
                tx_d_d       = SFD_BYTE;
                data_fifo_rd = 1'b1;
                state_d      = StData;
            end
            StData: begin
                tx_en_d = 1'b1;
                tx_d_d  = data_fifo_dout;
                crc_d   = crc_next;
                cnt_d   = cnt_q + 12'd1;
                if (last_data) begin
                    if (len_q < MIN_LEN_W) begin
                        state_d = StPad;
                    end else begin
                        cnt_d   = 12'd0;
                        state_d = StFcs;
                    end
                end else begin
                    data_fifo_rd = 1'b1;
                end
            end
            StPad: begin
                tx_en_d = 1'b1;
                crc_d   = crc_next;
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == MIN_LEN_W - 12'd1) begin
                    cnt_d   = 12'd0;
                    state_d = StFcs;
                end
            end
            StFcs: begin
                tx_en_d = 1'b1;
                tx_d_d  = fcs_byte;
                cnt_d   = cnt_q + 12'd1;
                if (cnt_q == 12'd3) begin
                    cnt_d       = 12'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = (IFG_BYTES == 0) ? after_frame : StIfg;
                end
            end
            StIfg: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = 12'd0;
                    state_d = after_frame;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 12'd0;
            len_q       <= 12'd0;
            crc_q       <= 32'd0;
            frame_cnt_q <= 16'd0;
            tx_en_q     <= 1'b0;
            tx_d_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            tx_en_q     <= tx_en_d;
            tx_d_q      <= tx_d_d;
        end
    end

    assign tx_en        = tx_en_q;
    assign tx_d         = tx_d_q;
    assign tx_frame_cnt = frame_cnt_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_switch_tx_mac.sv
// Scoreboard bench for switch_tx_mac: random frames against a byte-level framing/CRC model.
module tb_switch_tx_mac;

    localparam int IFG  = 12;
    localparam int MINL = 60;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ptr_fifo_rd, ptr_fifo_empty, data_fifo_rd, tx_en, busy;
    logic [15:0] ptr_fifo_dout, tx_frame_cnt;
    logic [7:0]  data_fifo_dout, tx_d;

    logic        ptr_rd0, ptr_empty0, data_rd0, tx_en0, busy0;
    logic [15:0] ptr_dout0, tx_frame_cnt0;
    logic [7:0]  data_dout0, tx_d0;
    logic        go0, popped0;
    int          idx0;

    always #5 clk = ~clk;

    switch_tx_mac #(.IFG_BYTES(IFG), .MIN_LEN(MINL)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .ptr_fifo_empty (ptr_fifo_empty),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .tx_en          (tx_en),
        .tx_d           (tx_d),
        .tx_frame_cnt   (tx_frame_cnt),
        .busy           (busy)
    );

    // Second instance without padding, for the published CRC check vector
    switch_tx_mac #(.IFG_BYTES(IFG), .MIN_LEN(0)) u_dut0 (
        .clk            (clk),
        .rstn           (rstn),
        .ptr_fifo_rd    (ptr_rd0),
        .ptr_fifo_dout  (ptr_dout0),
        .ptr_fifo_empty (ptr_empty0),
        .data_fifo_rd   (data_rd0),
        .data_fifo_dout (data_dout0),
        .tx_en          (tx_en0),
        .tx_d           (tx_d0),
        .tx_frame_cnt   (tx_frame_cnt0),
        .busy           (busy0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Non-FWFT FIFO models: dout updates on the edge that sees rd
    logic [15:0] ptr_q[$];
    logic [7:0]  dat_q[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_fifo_dout  <= 16'h0;
            data_fifo_dout <= 8'h0;
            ptr_fifo_empty <= 1'b1;
        end else begin
            if (ptr_fifo_rd && ptr_q.size() > 0) ptr_fifo_dout <= ptr_q.pop_front();
            if (data_fifo_rd && dat_q.size() > 0) data_fifo_dout <= dat_q.pop_front();
            ptr_fifo_empty <= (ptr_q.size() == 0);
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_dout0  <= 16'h0;
            data_dout0 <= 8'h0;
            ptr_empty0 <= 1'b1;
            popped0    <= 1'b0;
            idx0       <= 0;
        end else begin
            ptr_empty0 <= !(go0 && !popped0 && !ptr_rd0);
            if (ptr_rd0) begin
                ptr_dout0 <= 16'h0009;
                popped0   <= 1'b1;
            end
            if (data_rd0) begin
                data_dout0 <= 8'h31 + 8'(idx0);
                idx0       <= idx0 + 1;
            end
        end
    end

    // Reference model: expected wire bytes, frame lengths, read counts and gap rules
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    int          exp_rd_q[$];
    bit          exp_b2b_q[$];
    logic [7:0]  q0[$];

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic send_frame(input int len, input bit b2b);
        logic [7:0]  pl[$];
        logic [7:0]  b;
        logic [31:0] fcs;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pl.push_back(b);
            dat_q.push_back(b);
        end
        ptr_q.push_back({4'($urandom), 12'(len)});
        if (len == 0) return;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        while (pl.size() < MINL) pl.push_back(8'h00);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        fcs = crc32(pl);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs >> (8 * i)));
        exp_len_q.push_back(8 + pl.size() + 4);
        exp_rd_q.push_back(len);
        exp_b2b_q.push_back(b2b);
    endtask

    // Monitor: compares every wire cycle against the scoreboard
    bit          in_frame = 0;
    int          nbytes = 0, cur_len = 0, rd_cnt = 0, gap = 0, ptr_rd_cnt = 0;
    bit          cur_b2b = 0;
    logic [15:0] exp_cnt = 16'h0;

    always @(negedge clk) begin
        if (!rstn) begin
            in_frame = 0; nbytes = 0; rd_cnt = 0; gap = 0; exp_cnt = 16'h0;
        end else begin
            if (data_fifo_rd) rd_cnt++;
            if (ptr_fifo_rd) ptr_rd_cnt++;
            if (tx_en) begin
                if (!in_frame) begin
                    in_frame = 1;
                    nbytes   = 0;
                    check("frame_expected", 32'(exp_len_q.size() != 0), 1);
                    if (exp_len_q.size() != 0) begin
                        cur_len = exp_len_q.pop_front();
                        cur_b2b = exp_b2b_q.pop_front();
                        if (cur_b2b) check("ifg_gap", gap, IFG + 2);
                    end
                end
                check("byte_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_d", tx_d, exp_q.pop_front());
                nbytes++;
                if (nbytes == cur_len) begin
                    exp_cnt++;
                    check("frame_cnt_inc", tx_frame_cnt, exp_cnt);
                end else begin
                    check("frame_cnt_hold", tx_frame_cnt, exp_cnt);
                end
                gap = 0;
            end else begin
                check("idle_tx_d", tx_d, 0);
                if (in_frame) begin
                    in_frame = 0;
                    check("frame_len", nbytes, cur_len);
                    if (exp_rd_q.size() != 0) check("data_rd_cycles", rd_cnt, exp_rd_q.pop_front());
                    rd_cnt = 0;
                end
                gap++;
            end
        end
        if (rstn && tx_en0) q0.push_back(tx_d0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_len_q.size() != 0 || in_frame || busy || ptr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < budget), 1);
        check("data_fifo_drained", dat_q.size(), 0);
    endtask

    logic [7:0] vec0 [21] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h26, 8'h39, 8'hF4, 8'hCB};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        rstn = 1'b0;
        go0  = 1'b0;
        repeat (3) tick();
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_d", tx_d, 0);
        check("rst_frame_cnt", tx_frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr_rd", ptr_fifo_rd, 0);
        check("rst_data_rd", data_fifo_rd, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Known CRC vector on the unpadded instance
        go0 = 1'b1;
        n = 0;
        while (!(q0.size() >= 21 && !tx_en0 && !busy0) && n < 200) begin
            tick();
            n++;
        end
        check("vec_done_in_time", 32'(n < 200), 1);
        check("vec_tx_en_cycles", q0.size(), 21);
        for (int i = 0; i < 21 && i < q0.size(); i++) check("vec_byte", q0[i], vec0[i]);
        check("vec_frame_cnt", tx_frame_cnt0, 1);

        // Back-to-back batch: short padded, two 64s, boundary and random lengths
        send_frame(14, 0);
        send_frame(64, 1);
        send_frame(64, 1);
        send_frame(59, 1);
        send_frame(60, 1);
        send_frame(61, 1);
        for (int i = 0; i < 4; i++) send_frame(int'($urandom_range(1, 200)), 1);
        wait_done(6000);

        // Zero-length descriptor
        base = ptr_rd_cnt;
        send_frame(0, 0);
        n = 0;
        while (ptr_rd_cnt == base && n < 20) begin
            tick();
            n++;
        end
        check("zero_ptr_pulse_seen", 32'(n < 20), 1);
        repeat (3) tick();
        check("zero_busy_low", busy, 0);
        repeat (5) tick();
        check("zero_ptr_pulses", ptr_rd_cnt - base, 1);
        check("zero_frame_cnt", tx_frame_cnt, exp_cnt);

        // Maximum length
        send_frame(4095, 0);
        wait_done(6000);

        // Reset on payload byte 20 of a 100-byte frame
        send_frame(100, 0);
        n = 0;
        while (!(in_frame && nbytes == 29) && n < 300) begin
            tick();
            n++;
        end
        check("reach_byte20", 32'(n < 300), 1);
        check("pre_reset_cnt_nonzero", 32'(tx_frame_cnt != 0), 1);
        rstn = 1'b0;
        #1;
        check("abort_tx_en", tx_en, 0);
        check("abort_tx_d", tx_d, 0);
        check("abort_frame_cnt", tx_frame_cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_data_rd", data_fifo_rd, 0);
        ptr_q.delete(); dat_q.delete(); exp_q.delete();
        exp_len_q.delete(); exp_rd_q.delete(); exp_b2b_q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        send_frame(int'($urandom_range(1, 120)), 0);
        wait_done(2000);
        check("post_reset_cnt", tx_frame_cnt, 1);

        // Counter wrap
        force u_dut.frame_cnt_q = 16'hFFFF;
        #1;
        release u_dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        tick();
        send_frame(20, 0);
        wait_done(2000);
        check("wrap_cnt", tx_frame_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
